// File: rtl/field_pkg.sv
// Shared field definitions: precedence encodings, field attribute constants
// and the update-source selection helper used by field_store.
package field_pkg;

    // Precedence encodings for same-cycle software/hardware conflicts
    localparam int unsigned SW_PRIO = 0;
    localparam int unsigned HW_PRIO = 1;

    // Field attribute constants for counter overflow behaviour
    localparam int unsigned ATTR_WRAP = 0;
    localparam int unsigned ATTR_SAT  = 1;

    // Update source that drives the field on the next edge
    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_SW     = 3'd1,
        SRC_HW_WE  = 3'd2,
        SRC_HW_CLR = 3'd3,
        SRC_HW_SET = 3'd4,
        SRC_CNT    = 3'd5
    } src_e;

    // Pick the first active source in precedence order
    function automatic src_e select_src(
        input logic hw_first,
        input logic s_act,
        input logic hw_we,
        input logic hw_clr,
        input logic hw_set,
        input logic c_act
    );
        src_e src;
        src = SRC_NONE;
        if (!hw_first && s_act) src = SRC_SW;
        else if (hw_we)         src = SRC_HW_WE;
        else if (hw_clr)        src = SRC_HW_CLR;
        else if (hw_set)        src = SRC_HW_SET;
        else if (s_act)         src = SRC_SW;
        else if (c_act)         src = SRC_CNT;
        return src;
    endfunction

endpackage

// File: rtl/field_counter.sv
// Counter step for field_store: +1/-1 with optional saturation and
// carry/borrow based overflow/underflow detection. Purely combinational.
module field_counter #(
    parameter int unsigned F_WIDTH  = 4,
    parameter int unsigned INCR_SAT = 0,
    parameter int unsigned DECR_SAT = 0
) (
    input  logic [F_WIDTH-1:0] value,
    input  logic               incr,
    input  logic               decr,
    output logic               step_c,
    output logic [F_WIDTH-1:0] next_c,
    output logic               ovf_c,
    output logic               unf_c
);

    localparam int unsigned CW = F_WIDTH + 1;

    logic [CW-1:0] sum;
    logic [CW-1:0] diff;

    // One-bit-wider add/sub; the extra bit is only the carry/borrow flag
    always_comb begin
        sum    = CW'(value) + CW'(1);
        diff   = CW'(value) - CW'(1);
        step_c = incr ^ decr;
        next_c = value;
        ovf_c  = 1'b0;
        unf_c  = 1'b0;
        if (incr && !decr) begin
            ovf_c  = sum[F_WIDTH];
            next_c = (ovf_c && (INCR_SAT != 0)) ? value : sum[F_WIDTH-1:0];
        end else if (decr && !incr) begin
            unf_c  = diff[F_WIDTH];
            next_c = (unf_c && (DECR_SAT != 0)) ? value : diff[F_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/field_store.sv
// Register field storage with software/hardware update arbitration,
// write-once lock and change/counter event pulses.
// Optional counter logic is built when FIELD_STORE_CNT_EN is defined;
// otherwise incr/decr are ignored and the counter event outputs stay 0.
module field_store
    import field_pkg::*;
#(
    parameter int unsigned         F_WIDTH    = 4,
    parameter logic [F_WIDTH-1:0]  RESET_VAL  = '0,
    parameter int unsigned         PRECEDENCE = SW_PRIO,
    parameter int unsigned         INCR_SAT   = ATTR_WRAP,
    parameter int unsigned         DECR_SAT   = ATTR_WRAP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw_modify,
    input  logic [F_WIDTH-1:0] nxt_sw_value,
    input  logic               reset_modify,
    input  logic               hw_we,
    input  logic [F_WIDTH-1:0] hw_wr_data,
    input  logic               hw_set,
    input  logic               hw_clr,
    input  logic               incr,
    input  logic               decr,
    output logic [F_WIDTH-1:0] field_value,
    output logic               locked,
    output logic               changed,
    output logic               incr_overflow,
    output logic               decr_underflow
);

    logic [F_WIDTH-1:0] field_value_q, field_value_d;
    logic               locked_q, locked_d;
    logic               changed_q, changed_d;
    logic               incr_overflow_q, incr_overflow_d;
    logic               decr_underflow_q, decr_underflow_d;

    logic               cnt_step_c;
    logic [F_WIDTH-1:0] cnt_next_c;
    logic               cnt_ovf_c;
    logic               cnt_unf_c;
    logic               s_act_c;
    src_e               src_c;

`ifdef FIELD_STORE_CNT_EN
    field_counter #(
        .F_WIDTH  (F_WIDTH),
        .INCR_SAT (INCR_SAT),
        .DECR_SAT (DECR_SAT)
    ) u_counter (
        .value  (field_value_q),
        .incr   (incr),
        .decr   (decr),
        .step_c (cnt_step_c),
        .next_c (cnt_next_c),
        .ovf_c  (cnt_ovf_c),
        .unf_c  (cnt_unf_c)
    );
`else
    // Counter absent: step requests are masked off and never win selection
    assign cnt_step_c = (incr | decr) & 1'b0;
    assign cnt_next_c = field_value_q;
    assign cnt_ovf_c  = 1'b0;
    assign cnt_unf_c  = 1'b0;
`endif

    // Arbitrate update sources and compute next value, lock and pulses
    always_comb begin
        s_act_c          = sw_modify & ~locked_q;
        src_c            = select_src(1'(PRECEDENCE == HW_PRIO), s_act_c,
                                      hw_we, hw_clr, hw_set, cnt_step_c);
        field_value_d    = field_value_q;
        locked_d         = locked_q | (s_act_c & reset_modify);
        incr_overflow_d  = 1'b0;
        decr_underflow_d = 1'b0;
        case (src_c)
            SRC_SW:     field_value_d = nxt_sw_value;
            SRC_HW_WE:  field_value_d = hw_wr_data;
            SRC_HW_CLR: field_value_d = '0;
            SRC_HW_SET: field_value_d = '1;
            SRC_CNT: begin
                field_value_d    = cnt_next_c;
                incr_overflow_d  = cnt_ovf_c;
                decr_underflow_d = cnt_unf_c;
            end
            default:    field_value_d = field_value_q;
        endcase
        changed_d = (field_value_d != field_value_q);
    end

    // State and pulse registers; reset overrides every same-cycle request
    always_ff @(posedge clk) begin
        if (rst) begin
            field_value_q    <= RESET_VAL;
            locked_q         <= 1'b0;
            changed_q        <= 1'b0;
            incr_overflow_q  <= 1'b0;
            decr_underflow_q <= 1'b0;
        end else begin
            field_value_q    <= field_value_d;
            locked_q         <= locked_d;
            changed_q        <= changed_d;
            incr_overflow_q  <= incr_overflow_d;
            decr_underflow_q <= decr_underflow_d;
        end
    end

    assign field_value    = field_value_q;
    assign locked         = locked_q;
    assign changed        = changed_q;
    assign incr_overflow  = incr_overflow_q;
    assign decr_underflow = decr_underflow_q;

endmodule

// File: tb/tb_field_store.sv
// Directed bench for field_store. Two instances share the stimulus:
// d0 = software precedence, wrapping counter; d1 = hardware precedence,
// saturating counter. Counter checks follow FIELD_STORE_CNT_EN.
module tb_field_store;

    logic       clk = 1'b0;
    logic       rst;
    logic       sw_modify;
    logic [3:0] nxt_sw_value;
    logic       reset_modify;
    logic       hw_we;
    logic [3:0] hw_wr_data;
    logic       hw_set;
    logic       hw_clr;
    logic       incr;
    logic       decr;

    logic [3:0] v0, v1;
    logic       lk0, lk1, ch0, ch1, of0, of1, uf0, uf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    field_store #(.F_WIDTH(4), .RESET_VAL(4'h5), .PRECEDENCE(0),
                  .INCR_SAT(0), .DECR_SAT(0)) dut0 (
        .clk(clk), .rst(rst), .sw_modify(sw_modify), .nxt_sw_value(nxt_sw_value),
        .reset_modify(reset_modify), .hw_we(hw_we), .hw_wr_data(hw_wr_data),
        .hw_set(hw_set), .hw_clr(hw_clr), .incr(incr), .decr(decr),
        .field_value(v0), .locked(lk0), .changed(ch0),
        .incr_overflow(of0), .decr_underflow(uf0));

    field_store #(.F_WIDTH(4), .RESET_VAL(4'h5), .PRECEDENCE(1),
                  .INCR_SAT(1), .DECR_SAT(1)) dut1 (
        .clk(clk), .rst(rst), .sw_modify(sw_modify), .nxt_sw_value(nxt_sw_value),
        .reset_modify(reset_modify), .hw_we(hw_we), .hw_wr_data(hw_wr_data),
        .hw_set(hw_set), .hw_clr(hw_clr), .incr(incr), .decr(decr),
        .field_value(v1), .locked(lk1), .changed(ch1),
        .incr_overflow(of1), .decr_underflow(uf1));

    task automatic idle();
        rst = 1'b0; sw_modify = 1'b0; nxt_sw_value = 4'h0; reset_modify = 1'b0;
        hw_we = 1'b0; hw_wr_data = 4'h0; hw_set = 1'b0; hw_clr = 1'b0;
        incr = 1'b0; decr = 1'b0;
    endtask

    // Advance one edge and settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1'b1; hw_set = 1'b1;
        step();
        checks++; if (v0 !== 4'h5) begin errors++; $display("FAIL reset_val d0 got %h exp 5", v0); end
        checks++; if (v1 !== 4'h5) begin errors++; $display("FAIL reset_val d1 got %h exp 5", v1); end
        checks++; if ({lk0, ch0, of0, uf0, lk1, ch1, of1, uf1} !== 8'h00) begin
            errors++; $display("FAIL reset_flags got %b exp 00000000", {lk0, ch0, of0, uf0, lk1, ch1, of1, uf1}); end
        idle(); hw_set = 1'b1;
        step();
        checks++; if (v0 !== 4'hF || v1 !== 4'hF) begin errors++; $display("FAIL hw_set got %h/%h exp F/F", v0, v1); end
        checks++; if (ch0 !== 1'b1 || ch1 !== 1'b1) begin errors++; $display("FAIL set_changed got %b/%b exp 1/1", ch0, ch1); end
        idle();
        step();
        checks++; if (ch0 !== 1'b0 || ch1 !== 1'b0 || v0 !== 4'hF) begin
            errors++; $display("FAIL hold_changed got %b/%b v %h exp 0/0 v F", ch0, ch1, v0); end
    endtask

    task automatic test_precedence();
        idle(); sw_modify = 1'b1; nxt_sw_value = 4'h3; hw_we = 1'b1; hw_wr_data = 4'h9;
        step();
        checks++; if (v0 !== 4'h3) begin errors++; $display("FAIL prec_sw d0 got %h exp 3", v0); end
        checks++; if (v1 !== 4'h9) begin errors++; $display("FAIL prec_hw d1 got %h exp 9", v1); end
        idle(); sw_modify = 1'b1; nxt_sw_value = 4'h1; hw_we = 1'b1; hw_wr_data = 4'h8;
        step();
        idle();
        step();
        checks++; if (v0 !== 4'h1 || v1 !== 4'h8) begin errors++; $display("FAIL drop_hw got %h/%h exp 1/8", v0, v1); end
        hw_we = 1'b1; hw_wr_data = 4'h6; hw_clr = 1'b1; hw_set = 1'b1;
        step();
        checks++; if (v0 !== 4'h6 || v1 !== 4'h6) begin errors++; $display("FAIL hw_order_we got %h/%h exp 6/6", v0, v1); end
        idle(); hw_clr = 1'b1; hw_set = 1'b1;
        step();
        checks++; if (v0 !== 4'h0 || v1 !== 4'h0) begin errors++; $display("FAIL hw_order_clr got %h/%h exp 0/0", v0, v1); end
        idle(); hw_clr = 1'b1;
        step();
        checks++; if (ch0 !== 1'b0 || ch1 !== 1'b0) begin errors++; $display("FAIL same_reload got %b/%b exp 0/0", ch0, ch1); end
        idle();
    endtask

`ifdef FIELD_STORE_CNT_EN
    task automatic test_counter();
        idle(); hw_set = 1'b1;
        step();
        idle(); incr = 1'b1;
        step();
        checks++; if (v0 !== 4'h0 || v1 !== 4'hF) begin errors++; $display("FAIL incr_top got %h/%h exp 0/F", v0, v1); end
        checks++; if (of0 !== 1'b1 || of1 !== 1'b1) begin errors++; $display("FAIL incr_ovf got %b/%b exp 1/1", of0, of1); end
        checks++; if (ch0 !== 1'b1 || ch1 !== 1'b0) begin errors++; $display("FAIL incr_chg got %b/%b exp 1/0", ch0, ch1); end
        idle(); hw_clr = 1'b1;
        step();
        checks++; if (of0 !== 1'b0 || of1 !== 1'b0) begin errors++; $display("FAIL ovf_pulse got %b/%b exp 0/0", of0, of1); end
        idle(); decr = 1'b1;
        step();
        checks++; if (v0 !== 4'hF || v1 !== 4'h0) begin errors++; $display("FAIL decr_bot got %h/%h exp F/0", v0, v1); end
        checks++; if (uf0 !== 1'b1 || uf1 !== 1'b1) begin errors++; $display("FAIL decr_unf got %b/%b exp 1/1", uf0, uf1); end
        idle(); hw_we = 1'b1; hw_wr_data = 4'h5;
        step();
        idle(); incr = 1'b1; decr = 1'b1;
        step();
        checks++; if (v0 !== 4'h5 || v1 !== 4'h5 || {of0, uf0, ch0, of1, uf1, ch1} !== 6'b0) begin
            errors++; $display("FAIL cancel got %h/%h pulses %b exp 5/5 000000", v0, v1, {of0, uf0, ch0, of1, uf1, ch1}); end
        idle(); incr = 1'b1;
        step();
        checks++; if (v0 !== 4'h6 || v1 !== 4'h6 || of0 !== 1'b0) begin errors++; $display("FAIL incr_mid got %h/%h ovf %b exp 6/6 0", v0, v1, of0); end
        idle(); hw_set = 1'b1;
        step();
        idle(); incr = 1'b1; hw_clr = 1'b1;
        step();
        checks++; if (v0 !== 4'h0 || v1 !== 4'h0 || of0 !== 1'b0 || of1 !== 1'b0) begin
            errors++; $display("FAIL incr_override got %h/%h ovf %b/%b exp 0/0 0/0", v0, v1, of0, of1); end
        idle();
    endtask
`else
    task automatic test_no_counter();
        idle(); hw_we = 1'b1; hw_wr_data = 4'h5;
        step();
        idle(); incr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (v0 !== 4'h5 || v1 !== 4'h5 || of0 !== 1'b0 || of1 !== 1'b0) begin
                errors++; $display("FAIL no_cnt_incr[%0d] got %h/%h ovf %b/%b exp 5/5 0/0", i, v0, v1, of0, of1); end
        end
        idle(); hw_clr = 1'b1;
        step();
        idle(); decr = 1'b1;
        step();
        checks++; if (v0 !== 4'h0 || uf0 !== 1'b0 || uf1 !== 1'b0) begin
            errors++; $display("FAIL no_cnt_decr got %h unf %b/%b exp 0 0/0", v0, uf0, uf1); end
        idle();
    endtask
`endif

    task automatic test_lock();
        idle(); sw_modify = 1'b1; reset_modify = 1'b1; nxt_sw_value = 4'hA;
        step();
        checks++; if (v0 !== 4'hA || v1 !== 4'hA) begin errors++; $display("FAIL lock_load got %h/%h exp A/A", v0, v1); end
        checks++; if (lk0 !== 1'b1 || lk1 !== 1'b1) begin errors++; $display("FAIL lock_set got %b/%b exp 1/1", lk0, lk1); end
        idle(); sw_modify = 1'b1; nxt_sw_value = 4'h2;
        step();
        checks++; if (v0 !== 4'hA || v1 !== 4'hA) begin errors++; $display("FAIL lock_hold got %h/%h exp A/A", v0, v1); end
        hw_we = 1'b1; hw_wr_data = 4'h7;
        step();
        checks++; if (v0 !== 4'h7 || v1 !== 4'h7) begin errors++; $display("FAIL lock_hw got %h/%h exp 7/7", v0, v1); end
        idle(); rst = 1'b1; hw_we = 1'b1; hw_wr_data = 4'h9;
        step();
        checks++; if (lk0 !== 1'b0 || lk1 !== 1'b0 || v0 !== 4'h5 || ch0 !== 1'b0) begin
            errors++; $display("FAIL lock_rst got %b/%b v %h ch %b exp 0/0 v 5 ch 0", lk0, lk1, v0, ch0); end
        idle(); sw_modify = 1'b1; nxt_sw_value = 4'h2;
        step();
        checks++; if (v0 !== 4'h2 || v1 !== 4'h2 || ch0 !== 1'b1) begin
            errors++; $display("FAIL post_rst got %h/%h ch %b exp 2/2 1", v0, v1, ch0); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_precedence();
`ifdef FIELD_STORE_CNT_EN
        test_counter();
`else
        test_no_counter();
`endif
        test_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/field_store.md
FIELD_STORE -- requirements
Module: field_store

Interface
REQ-001 SHALL have parameter F_WIDTH, default 4, field width in bits.
REQ-002 SHALL have parameter RESET_VAL [F_WIDTH-1:0], default 0, value loaded on reset.
REQ-003 SHALL have parameter PRECEDENCE, default 0, 0 = software wins and 1 = hardware wins on same-cycle conflict.
REQ-004 SHALL have parameter INCR_SAT, default 0, 1 = increment saturates at all-ones and 0 = increment wraps.
REQ-005 SHALL have parameter DECR_SAT, default 0, 1 = decrement saturates at zero and 0 = decrement wraps.
REQ-006 SHALL have the ports clk (input, 1): the single clock; all state updates on its rising edge.
REQ-007 SHALL have rst (input, 1): synchronous, active-high reset.
REQ-008 SHALL have sw_modify (input, 1): software update request from the software-control stage.
REQ-009 SHALL have nxt_sw_value (input, F_WIDTH): software next value.
REQ-010 SHALL have reset_modify (input, 1): software update that arms the write-once lock.
REQ-011 SHALL have hw_we (input, 1) and hw_wr_data (input, F_WIDTH): hardware write.
REQ-012 SHALL have hw_set (input, 1) and hw_clr (input, 1): hardware set all bits and clear all bits.
REQ-013 SHALL have incr (input, 1) and decr (input, 1): counter step requests of +1 and -1.
REQ-014 SHALL have field_value (output, F_WIDTH): stored value, fed back to the software-control stage.
REQ-015 SHALL have locked (output, 1): write-once lock state.
REQ-016 SHALL have changed (output, 1): registered one-cycle pulse marking a value change.
REQ-017 SHALL have incr_overflow (output, 1) and decr_underflow (output, 1): registered one-cycle counter event pulses.

Function
REQ-018 Update sources SHALL be: S = sw_modify & ~locked; H = hw_we | hw_clr | hw_set; C = incr ^ decr.
REQ-019 With PRECEDENCE=0, selection SHALL be S, then hw_we, then hw_clr, then hw_set, then C; the first active source wins.
REQ-020 With PRECEDENCE=1, selection SHALL be hw_we, then hw_clr, then hw_set, then S, then C.
REQ-021 The selected source SHALL update field_value on the next edge (1-cycle latency); with no source active, the value SHALL hold.
REQ-022 hw_set SHALL load all-ones; hw_clr SHALL load zero; hw_we SHALL load hw_wr_data; S SHALL load nxt_sw_value.
REQ-023 incr and decr both high SHALL cancel: no change and no pulse.
REQ-024 An increment from all-ones SHALL wrap to 0 if INCR_SAT=0 and hold all-ones if INCR_SAT=1; incr_overflow SHALL pulse in either case.
REQ-025 A decrement from 0 SHALL wrap to all-ones if DECR_SAT=0 and hold 0 if DECR_SAT=1; decr_underflow SHALL pulse in either case.
REQ-026 A counter step overridden by a higher-priority source SHALL be dropped and SHALL NOT pulse.
REQ-027 locked SHALL set on the edge after a cycle with S & reset_modify, and SHALL clear only on rst.
REQ-028 A hardware source that loses to S SHALL be dropped, not queued.
REQ-029 changed SHALL be high in the cycle after any edge where field_value took a different value; a reload of the same value SHALL NOT pulse.
REQ-030 All arithmetic SHALL be F_WIDTH bits, with the carry/borrow used only for overflow/underflow detection.

Reset
REQ-031 rst SHALL force field_value=RESET_VAL and locked, changed, incr_overflow, decr_underflow=0, overriding all same-cycle requests.
REQ-032 rst asserted mid-operation SHALL discard pending pulses; the first edge after rst deasserts SHALL act normally.

Configuration
REQ-033 Macro FIELD_STORE_CNT_EN defined SHALL include counter logic per REQ-023..026.
REQ-034 Without FIELD_STORE_CNT_EN: incr and decr SHALL be ignored, incr_overflow and decr_underflow SHALL be tied 0, and the ports SHALL remain.

Structure
REQ-035 Precedence encodings (SW_PRIO, HW_PRIO) SHALL be defined in shared package field_pkg, alongside the existing field attribute constants.
REQ-036 The counter step, saturation and event detection SHALL be sub-module field_counter, instantiated only under FIELD_STORE_CNT_EN.

Verification (F_WIDTH=4, RESET_VAL=4'h5)
REQ-037 rst for 1 cycle with hw_set=1 -> field_value=5, all pulses 0; next cycle hw_set -> F, changed pulse.
REQ-038 PRECEDENCE=0, same cycle sw_modify=1/nxt_sw_value=3 and hw_we=1/hw_wr_data=9 -> 3; repeat with PRECEDENCE=1 -> 9.
REQ-039 Value F, incr: INCR_SAT=0 -> 0 with incr_overflow pulse; INCR_SAT=1 -> F with incr_overflow pulse.
REQ-040 sw_modify+reset_modify with value A -> A and locked=1; later sw_modify value 2 -> holds A; hw_we 7 -> 7; rst -> locked=0.
REQ-041 incr=decr=1 at 5 -> stays 5, no pulses; incr together with hw_clr -> 0, no overflow pulse.
REQ-042 Build without FIELD_STORE_CNT_EN, incr held 4 cycles at 5 -> stays 5, incr_overflow=0.
